// File: rtl/mmu_stream_ctrl_pkg.sv
// Shared encodings and sizes for the mmu byte-stream controller.
package mmu_stream_ctrl_pkg;

    typedef enum logic [1:0] {
        StLoad  = 2'd0,
        StRun   = 2'd1,
        StWait  = 2'd2,
        StDrain = 2'd3
    } state_e;

    localparam int unsigned MMU_BYTES_IN   = 8;
    localparam int unsigned MMU_BYTES_OUT  = 4;
    localparam int unsigned MMU_RUN_CYCLES = 3;

endpackage

// File: rtl/mmu_stream_ctrl_if.sv
// Byte-stream input and output handshakes of the mmu stream controller.
interface mmu_stream_ctrl_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );
endinterface

// File: rtl/mmu_stream_ctrl.sv
// Packs 8 operand bytes for the 2x2 int8 mmu, sequences start/done and
// streams the 4 result bytes back out.
module mmu_stream_ctrl
    import mmu_stream_ctrl_pkg::*;
#(
    parameter int unsigned DONE_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    mmu_stream_ctrl_if.slave  s,
    output logic [31:0]       mmu_a,
    output logic [31:0]       mmu_b,
    output logic              mmu_start,
    input  logic [31:0]       mmu_c,
    input  logic              mmu_done,
    output logic              err
);

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d, idx_inc;
    logic [1:0]  run_cnt_q, run_cnt_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [7:0]  out_q, out_d;
    logic        start_q, start_d;
    logic        err_q, err_d;

    assign idx_inc = idx_q + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StLoad;
            idx_q      <= '0;
            run_cnt_q  <= '0;
            wait_cnt_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            out_q      <= '0;
            start_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            run_cnt_q  <= run_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            out_q      <= out_d;
            start_q    <= start_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        run_cnt_d  = run_cnt_q;
        wait_cnt_d = wait_cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        out_d      = out_q;
        start_d    = start_q;
        err_d      = 1'b0;
        unique case (state_q)
            StLoad: begin
                if (s.in_valid) begin
                    // idx bit 2 selects the B operand, bits 1:0 the byte lane
                    if (idx_q[2]) b_d[{idx_q[1:0], 3'b000} +: 8] = s.in_data;
                    else          a_d[{idx_q[1:0], 3'b000} +: 8] = s.in_data;
                    if (idx_q == 3'(MMU_BYTES_IN - 1)) begin
                        idx_d     = '0;
                        start_d   = 1'b1;
                        run_cnt_d = '0;
                        state_d   = StRun;
                    end else begin
                        idx_d = idx_inc;
                    end
                end
            end
            StRun: begin
                if (run_cnt_q == 2'(MMU_RUN_CYCLES - 1)) begin
                    start_d    = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = StWait;
                end else begin
                    run_cnt_d = run_cnt_q + 2'd1;
                end
            end
            StWait: begin
                if (mmu_done) begin
                    res_d   = mmu_c;
                    out_d   = mmu_c[7:0];
                    state_d = StDrain;
                end else if (wait_cnt_q == 4'(DONE_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StLoad;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            StDrain: begin
                if (s.out_ready) begin
                    if (idx_q == 3'(MMU_BYTES_OUT - 1)) begin
                        idx_d   = '0;
                        state_d = StLoad;
                    end else begin
                        idx_d = idx_inc;
                        out_d = res_q[{idx_inc[1:0], 3'b000} +: 8];
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    assign s.in_ready  = (state_q == StLoad);
    assign s.out_valid = (state_q == StDrain);
    assign s.out_data  = out_q;
    assign mmu_a       = a_q;
    assign mmu_b       = b_q;
    assign mmu_start   = start_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mmu_stream_ctrl.sv
// Bench for mmu_stream_ctrl with a behavioural 2x2 mmu and an expected-byte queue.
module tb_mmu_stream_ctrl;

    typedef logic [7:0] ops_t [8];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mmu_a, mmu_b, mmu_c;
    logic        mmu_start, mmu_done, err;
    logic        stub = 1'b0;
    logic [1:0]  mmu_cnt;
    int          vectors = 0;
    int          miscompares = 0;
    int          err_cnt = 0;
    logic [7:0]  exp_q[$];

    mmu_stream_ctrl_if bus();

    mmu_stream_ctrl #(.DONE_TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .s         (bus),
        .mmu_a     (mmu_a),
        .mmu_b     (mmu_b),
        .mmu_start (mmu_start),
        .mmu_c     (mmu_c),
        .mmu_done  (mmu_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] matmul(input logic [31:0] a, input logic [31:0] b);
        logic [7:0] c00, c01, c10, c11;
        c00 = a[7:0]   * b[7:0]  + a[15:8]  * b[23:16];
        c01 = a[7:0]   * b[15:8] + a[15:8]  * b[31:24];
        c10 = a[23:16] * b[7:0]  + a[31:24] * b[23:16];
        c11 = a[23:16] * b[15:8] + a[31:24] * b[31:24];
        return {c11, c10, c01, c00};
    endfunction

    // mmu model: registers done after 3 start cycles; stub mode never signals done
    always @(posedge clk) begin
        if (rst) begin
            mmu_cnt  <= 2'd0;
            mmu_done <= 1'b0;
            mmu_c    <= 32'd0;
        end else if (mmu_start) begin
            if (mmu_cnt == 2'd2) begin
                mmu_cnt  <= 2'd0;
                mmu_done <= !stub;
                mmu_c    <= matmul(mmu_a, mmu_b);
            end else begin
                mmu_cnt  <= mmu_cnt + 2'd1;
                mmu_done <= 1'b0;
            end
        end
    end

    always @(negedge clk) if (!rst && err) err_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int gap, output logic ok);
        ok = 1'b0;
        repeat (gap) @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_ops(input ops_t ops, input int gap, output logic ok);
        logic one;
        ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send_byte(ops[k], gap, one);
            ok &= one;
        end
    endtask

    task automatic push_exp(input logic [7:0] e0, e1, e2, e3);
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        exp_q.push_back(e3);
    endtask

    task automatic recv_byte(input int stall, output logic [7:0] b, output logic ok,
                             output logic stable);
        logic [7:0] first;
        ok = 1'b0;
        stable = 1'b1;
        b = 8'd0;
        bus.out_ready = (stall == 0);
        for (int i = 0; i < 100; i++) begin
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            first = bus.out_data;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                if (!bus.out_valid || bus.out_data !== first) stable = 1'b0;
            end
            bus.out_ready = 1'b1;
            b = bus.out_data;
            @(negedge clk);
            if (stall != 0) bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        vectors += 7;
        if (bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready);
        end
        if (bus.out_valid !== 1'b0) begin
            miscompares++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid);
        end
        if (bus.out_data !== 8'd0) begin
            miscompares++; $display("FAIL rst_out_data got %0d want 0", bus.out_data);
        end
        if (mmu_a !== 32'd0) begin
            miscompares++; $display("FAIL rst_mmu_a got %h want 0", mmu_a);
        end
        if (mmu_b !== 32'd0) begin
            miscompares++; $display("FAIL rst_mmu_b got %h want 0", mmu_b);
        end
        if (mmu_start !== 1'b0) begin
            miscompares++; $display("FAIL rst_mmu_start got %b want 0", mmu_start);
        end
        if (err !== 1'b0) begin
            miscompares++; $display("FAIL rst_err got %b want 0", err);
        end
    endtask

    task automatic test_basic();
        ops_t ops = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        logic ok, st;
        logic [7:0] b, e;
        int e0 = err_cnt;
        push_exp(8'd19, 8'd22, 8'd43, 8'd50);
        send_ops(ops, 0, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL basic_send got timeout want accept"); end
        for (int k = 0; k < 4; k++) begin
            recv_byte(0, b, ok, st);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            vectors++;
            if (!ok || b !== e) begin
                miscompares++; $display("FAIL basic_byte%0d got %0d ok=%b want %0d", k, b, ok, e);
            end
        end
        vectors++;
        if (err_cnt !== e0) begin
            miscompares++; $display("FAIL basic_err got %0d pulses want 0", err_cnt - e0);
        end
    endtask

    task automatic test_wrap();
        ops_t ops = '{8'd16, 8'd16, 8'd16, 8'd16, 8'd16, 8'd16, 8'd16, 8'd16};
        logic ok, st;
        logic [7:0] b, e;
        push_exp(8'd0, 8'd0, 8'd0, 8'd0);
        send_ops(ops, 0, ok);
        for (int k = 0; k < 4; k++) begin
            recv_byte(0, b, ok, st);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            vectors++;
            if (!ok || b !== e) begin
                miscompares++; $display("FAIL wrap_byte%0d got %0d ok=%b want %0d", k, b, ok, e);
            end
        end
    endtask

    task automatic test_backpressure();
        ops_t ops = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        logic ok, st;
        logic [7:0] b, e;
        push_exp(8'd19, 8'd22, 8'd43, 8'd50);
        send_ops(ops, 1, ok);
        for (int k = 0; k < 4; k++) begin
            recv_byte(3, b, ok, st);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            vectors += 2;
            if (!ok || b !== e) begin
                miscompares++; $display("FAIL bp_byte%0d got %0d ok=%b want %0d", k, b, ok, e);
            end
            if (st !== 1'b1) begin
                miscompares++; $display("FAIL bp_stable%0d got unstable want stable", k);
            end
        end
    endtask

    task automatic test_reset_mid();
        ops_t ops = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        logic ok, st;
        logic [7:0] b, e;
        for (int k = 0; k < 5; k++) send_byte(ops[k], 0, ok);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors += 3;
        if (mmu_a !== 32'd0) begin
            miscompares++; $display("FAIL midrst_mmu_a got %h want 0", mmu_a);
        end
        if (mmu_b !== 32'd0) begin
            miscompares++; $display("FAIL midrst_mmu_b got %h want 0", mmu_b);
        end
        if (bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL midrst_in_ready got %b want 1", bus.in_ready);
        end
        push_exp(8'd19, 8'd22, 8'd43, 8'd50);
        send_ops(ops, 0, ok);
        for (int k = 0; k < 4; k++) begin
            recv_byte(0, b, ok, st);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            vectors++;
            if (!ok || b !== e) begin
                miscompares++; $display("FAIL midrst_byte%0d got %0d ok=%b want %0d", k, b, ok, e);
            end
        end
    endtask

    task automatic test_timeout();
        ops_t ops = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        logic ok;
        int n = 0;
        int e0;
        stub = 1'b1;
        send_ops(ops, 0, ok);
        for (int i = 0; i < 20; i++) begin
            if (!mmu_start) break;
            @(negedge clk);
        end
        e0 = err_cnt;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (err) break;
        end
        vectors += 4;
        if (n !== 15 || err !== 1'b1) begin
            miscompares++; $display("FAIL timeout_delay got %0d cycles err=%b want 15", n, err);
        end
        if (bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL timeout_in_ready got %b want 1", bus.in_ready);
        end
        @(negedge clk);
        if (err !== 1'b0) begin
            miscompares++; $display("FAIL timeout_pulse_width got err=%b want 0", err);
        end
        if (err_cnt - e0 !== 1) begin
            miscompares++; $display("FAIL timeout_count got %0d pulses want 1", err_cnt - e0);
        end
        stub = 1'b0;
    endtask

    task automatic test_back_to_back();
        ops_t ops1 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        ops_t ops2 = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0, 8'd0, 8'd1};
        logic ok, st;
        logic [7:0] b, e;
        push_exp(8'd19, 8'd22, 8'd43, 8'd50);
        push_exp(8'd1, 8'd0, 8'd0, 8'd1);
        for (int s = 0; s < 2; s++) begin
            send_ops((s == 0) ? ops1 : ops2, 0, ok);
            for (int k = 0; k < 4; k++) begin
                recv_byte(0, b, ok, st);
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                vectors++;
                if (!ok || b !== e) begin
                    miscompares++;
                    $display("FAIL b2b_set%0d_byte%0d got %0d ok=%b want %0d", s, k, b, ok, e);
                end
            end
            vectors++;
            if (bus.in_ready !== 1'b1) begin
                miscompares++; $display("FAIL b2b_ready%0d got %b want 1", s, bus.in_ready);
            end
        end
    endtask

    initial begin
        bus.in_data   = 8'd0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_timeout();
        test_back_to_back();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++; $display("FAIL leftover_expected got %0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
